// File: rtl/mod4051_accum.sv
// mod4051_accum
//   Frame accumulator that sums partial residues coming out of an upstream
//   LUT stage and reduces them modulo MOD. Each frame is a run of beats
//   that ends with in_last. The final residue and the beat count are then
//   presented on a registered output and held until the consumer takes them.
//
// Parameters
//   The modulus parameter is applied to every accumulation and must be
//   below 2**W; W is the residue width in bits.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : upstream beat present
//   in_ready   : block can accept a beat (low while a result is held)
//   in_data    : partial residue, 0..2**W-1
//   in_last    : final beat of the frame
//   out_valid  : frame residue available
//   out_ready  : downstream takes the result
//   out_data   : frame residue, always < MOD
//   out_beats  : beats in the frame, saturating at 255
module mod4051_accum #(
  parameter int MOD = 4051,
  parameter int W   = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [7:0]   out_beats
);

  localparam logic [W-1:0] MOD_W = W'(MOD);
  localparam logic [W:0]   MOD_S = (W+1)'(MOD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t       state_q;
  logic [W-1:0] acc_q;
  logic [7:0]   beats_q;
  logic [W-1:0] out_data_q;
  logic [7:0]   out_beats_q;
  logic         out_valid_q;

  logic [W-1:0] din_red;
  logic [W:0]   sum;
  logic [W-1:0] acc_d;
  logic [7:0]   beats_d;
  logic         accept;

  assign in_ready  = (state_q != S_HOLD);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_beats = out_beats_q;

  // Residue update for the beat on the bus. A single conditional subtract
  // on the input is enough because any W-bit value is below 2*MOD; the sum
  // of two values below MOD is then below 2*MOD, so one more conditional
  // subtract brings it back into range.
  always_comb begin
    din_red = (in_data >= MOD_W) ? (in_data - MOD_W) : in_data;
    sum     = {1'b0, acc_q} + {1'b0, din_red};
    acc_d   = din_red;
    beats_d = 8'd1;
    if (state_q == S_ACC) begin
      acc_d   = (sum >= MOD_S) ? W'(sum - MOD_S) : sum[W-1:0];
      beats_d = (beats_q == 8'd255) ? beats_q : (beats_q + 8'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      beats_q     <= '0;
      out_data_q  <= '0;
      out_beats_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ACC: begin
          if (accept) begin
            acc_q   <= acc_d;
            beats_q <= beats_d;
            if (in_last) begin
              out_data_q  <= acc_d;
              out_beats_q <= beats_d;
              out_valid_q <= 1'b1;
              state_q     <= S_HOLD;
            end else begin
              state_q <= S_ACC;
            end
          end
        end
        S_HOLD: begin
          // in_ready is low here, so no beat can slip in on the exit cycle.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod4051_accum.sv
// Directed bench for mod4051_accum. Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point, away from the edge.
module tb_mod4051_accum;

  localparam int MOD = 4051;
  localparam int W   = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [7:0]   out_beats;

  int total = 0;
  int bad   = 0;

  mod4051_accum #(.MOD(MOD), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_beats (out_beats)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic drive_beat(input logic [W-1:0] d, input logic last);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL beat_ready_timeout: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Check the held result, then consume it.
  task automatic collect(input string name, input int exp_data, input int exp_beats);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_valid: got=%b want=1", name, out_valid);
    end
    total++;
    if (out_data !== W'(exp_data)) begin
      bad++;
      $display("FAIL %s_data: got=%0d want=%0d", name, out_data, exp_data);
    end
    total++;
    if (out_beats !== 8'(exp_beats)) begin
      bad++;
      $display("FAIL %s_beats: got=%0d want=%0d", name, out_beats, exp_beats);
    end
    $display("frame %s: data=%0d beats=%0d (want %0d/%0d)", name, out_data, out_beats, exp_data, exp_beats);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_beats !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b data=%0d beats=%0d want 0/0/0", out_valid, out_data, out_beats);
    end
    rst = 1'b0;
    step();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got=%b want=1", in_ready);
    end
    $display("reset: valid=%b data=%0d beats=%0d ready=%b", out_valid, out_data, out_beats, in_ready);
  endtask

  task automatic test_basic();
    drive_beat(12'd4000, 1'b0);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_early_valid: got=%b want=0", out_valid);
    end
    drive_beat(12'd100, 1'b1);
    collect("basic", 49, 2);
  endtask

  task automatic test_prereduce();
    drive_beat(12'd4050, 1'b0);
    drive_beat(12'd4050, 1'b0);
    drive_beat(12'd4050, 1'b1);
    collect("triple4050", 4048, 3);
    drive_beat(12'd4095, 1'b1);
    collect("single4095", 44, 1);
    drive_beat(12'd4051, 1'b1);
    collect("single4051", 0, 1);
  endtask

  task automatic test_idle_gap();
    drive_beat(12'd3000, 1'b0);
    in_data = 12'd777;
    for (int i = 0; i < 3; i++) step();
    drive_beat(12'd1500, 1'b1);
    collect("gap", 449, 2);
  endtask

  task automatic test_hold();
    drive_beat(12'd10, 1'b0);
    drive_beat(12'd20, 1'b1);
    in_valid = 1'b1;
    in_data  = 12'd5;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 12'd30 || out_beats !== 8'd2) begin
        bad++;
        $display("FAIL hold_stable: ready=%b valid=%b data=%0d beats=%0d want 0/1/30/2",
                 in_ready, out_valid, out_data, out_beats);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL hold_exit: valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    collect("after_hold", 5, 1);
  endtask

  task automatic test_reset_mid();
    drive_beat(12'd100, 1'b0);
    drive_beat(12'd200, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    drive_beat(12'd1, 1'b0);
    drive_beat(12'd2, 1'b1);
    collect("after_reset", 3, 2);
    // Reset while a result is pending and a beat is offered.
    drive_beat(12'd9, 1'b1);
    in_valid = 1'b1;
    in_data  = 12'd1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_hold: valid=%b data=%0d ready=%b want 0/0/1", out_valid, out_data, in_ready);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) drive_beat(12'd1, (i == 299));
    collect("sat300", 300, 255);
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int len;
      int sum;
      int v;
      len = $urandom_range(1, 20);
      sum = 0;
      for (int i = 0; i < len; i++) begin
        v = $urandom_range(0, 4095);
        sum += v;
        drive_beat(W'(v), (i == len - 1));
      end
      collect("random", sum % MOD, len);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_prereduce();
    test_idle_gap();
    test_hold();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mod4051_accum.md
MOD4051_ACCUM -- requirements
Module: mod4051_accum

Interface
REQ-001 Parameter MOD, default 4051, is the modulus applied to every accumulation.
REQ-002 Parameter W, default 12, is the residue width in bits; MOD SHALL be < 2^W.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  upstream LUT-stage residue beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_data  input  W  partial residue from one 6-bit LUT slice, 0..2^W-1.
REQ-008 in_last  input  1  marks the final beat of a frame.
REQ-009 out_valid  output  1  final residue available.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  W  frame residue, always < MOD.
REQ-012 out_beats  output  8  number of beats in the frame, saturating at 255.

Function
REQ-013 A beat SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-014 States: IDLE (no frame open), ACC (frame open), HOLD (result waiting).
REQ-015 in_ready SHALL be 1 in IDLE and ACC, and 0 in HOLD.
REQ-016 Pre-reduction: each accepted in_data >= MOD SHALL be reduced to d = in_data - MOD; otherwise d = in_data.
REQ-017 First beat, accepted in IDLE: acc = d and beats = 1.
REQ-018 Later beat, accepted in ACC: s = acc + d computed at W+1 bits; acc = s - MOD if s >= MOD, else s; beats increments, saturating at 255.
REQ-019 Accepted beat with in_last=0: next state SHALL be ACC.
REQ-020 Accepted beat with in_last=1, from either IDLE or ACC: the updated residue SHALL load into out_data, beats into out_beats, out_valid rises next cycle, and state goes to HOLD.
REQ-021 A single-beat frame (in_last=1 on the first beat) is legal and yields out_data = d.
REQ-022 Latency: out_valid SHALL be 1 exactly one cycle after the last beat is accepted.
REQ-023 HOLD: out_data, out_beats and out_valid SHALL stay stable until out_ready=1; on that cycle state goes to IDLE and out_valid drops next cycle.
REQ-024 No bypass: on the HOLD-exit cycle in_ready is still 0, so a new frame is accepted no earlier than the following cycle.
REQ-025 In IDLE and ACC, a cycle with in_valid=0 SHALL leave acc, beats and state unchanged.
REQ-026 out_data SHALL equal the sum of all frame in_data mod MOD, for any frame length.

Reset
REQ-027 While rst=1, state SHALL be IDLE, acc=0, beats=0, out_data=0, out_beats=0 and out_valid=0 on the next edge; in_ready SHALL be 1 after reset.
REQ-028 rst has priority over any simultaneous handshake; a partial frame or pending result is discarded and in_ready SHALL be 1 the cycle after reset deasserts.

Verification
REQ-029 Frame {4000, 100}, last on beat 2 -> out_data=49, out_beats=2, out_valid one cycle after the last accept.
REQ-030 Frame {4050, 4050, 4050} -> out_data=4048, out_beats=3.
REQ-031 Single beat 4095 with in_last=1 -> out_data=44, out_beats=1.
REQ-032 Result pending with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> IDLE, next frame accepted the cycle after.
REQ-033 rst pulsed after 2 beats of a 4-beat frame, then frame {1, 2} -> out_data=3, out_beats=2.
REQ-034 300-beat frame of 1 -> out_data=300, out_beats=255; random frames checked against a mod-4051 reference model.
